// File: rtl/otter_int_ctrl.sv
// otter_int_ctrl: machine-level interrupt controller for the OTTER core.
// Synchronizes and debounces the external button (MEI), registers the
// timer (MTI) and software (MSI) levels, and runs a request/ack/return
// handshake with the pipeline that presents one prioritized mcause at a time.
module otter_int_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BTN,
  input  logic        TIMER_INT,
  input  logic        SW_INT,
  input  logic        MIE_GLOBAL,
  input  logic [2:0]  MIE_MASK,
  input  logic        INTR_ACK,
  input  logic        MRET,
  output logic        INTR_REQ,
  output logic [31:0] INTR_CAUSE,
  output logic [2:0]  MIP
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_HANDLER = 2'd2;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic             msi_q, msi_d;
  logic             mti_q, mti_d;
  logic             mei_q, mei_d;
  logic [1:0]       state_q, state_d;
  logic             intr_req_q, intr_req_d;
  logic [31:0]      cause_q, cause_d;

  logic             btn_rise;
  logic             mei_clr;
  logic [2:0]       mip;
  logic [2:0]       eligible;

  assign mip        = {mei_q, mti_q, msi_q};
  assign eligible   = mip & MIE_MASK & {3{MIE_GLOBAL}};
  assign MIP        = mip;
  assign INTR_REQ   = intr_req_q;
  assign INTR_CAUSE = cause_q;

  // Button synchronizer, debounce counter and rising-edge detect.
  // The counter only runs while the synchronized sample disagrees with the
  // accepted level; any agreeing sample restarts the count.
  always_comb begin
    sync1_d  = BTN;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    db_d     = db_q;
    db_dly_d = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    btn_rise = db_q & ~db_dly_q;
  end

  // Request/handshake FSM, cause latch and pending bits.
  // The cause is captured only on IDLE->REQ so it stays frozen through
  // REQ and HANDLER. A new button edge beats an ack-driven MEI clear.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    mei_clr    = 1'b0;
    msi_d      = SW_INT;
    mti_d      = TIMER_INT;
    case (state_q)
      S_IDLE: begin
        if (eligible != 3'b000) begin
          state_d = S_REQ;
          if (eligible[2])      cause_d = CAUSE_MEI;
          else if (eligible[0]) cause_d = CAUSE_MSI;
          else                  cause_d = CAUSE_MTI;
        end
      end
      S_REQ: begin
        if (INTR_ACK) begin
          state_d = S_HANDLER;
          mei_clr = (cause_q == CAUSE_MEI);
        end
      end
      S_HANDLER: begin
        if (MRET) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    mei_d      = btn_rise | (mei_q & ~mei_clr);
    intr_req_d = (state_d == S_REQ);
  end

  // State registers; reset clears every flop including the synchronizer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      db_q       <= 1'b0;
      db_dly_q   <= 1'b0;
      msi_q      <= 1'b0;
      mti_q      <= 1'b0;
      mei_q      <= 1'b0;
      state_q    <= S_IDLE;
      intr_req_q <= 1'b0;
      cause_q    <= 32'h0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      db_dly_q   <= db_dly_d;
      msi_q      <= msi_d;
      mti_q      <= mti_d;
      mei_q      <= mei_d;
      state_q    <= state_d;
      intr_req_q <= intr_req_d;
      cause_q    <= cause_d;
    end
  end

endmodule

// File: tb/tb_otter_int_ctrl.sv
// Testbench for otter_int_ctrl: scenario tasks with a cause scoreboard.
module tb_otter_int_ctrl;

  localparam int DB = 4;
  localparam logic [31:0] C_MSI = 32'h8000_0003;
  localparam logic [31:0] C_MTI = 32'h8000_0007;
  localparam logic [31:0] C_MEI = 32'h8000_000B;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        BTN = 1'b0;
  logic        TIMER_INT = 1'b0;
  logic        SW_INT = 1'b0;
  logic        MIE_GLOBAL = 1'b0;
  logic [2:0]  MIE_MASK = 3'b000;
  logic        INTR_ACK = 1'b0;
  logic        MRET = 1'b0;
  logic        INTR_REQ;
  logic [31:0] INTR_CAUSE;
  logic [2:0]  MIP;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_c;
  bit          got;

  otter_int_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK(clk), .RST(RST), .BTN(BTN), .TIMER_INT(TIMER_INT), .SW_INT(SW_INT),
    .MIE_GLOBAL(MIE_GLOBAL), .MIE_MASK(MIE_MASK), .INTR_ACK(INTR_ACK),
    .MRET(MRET), .INTR_REQ(INTR_REQ), .INTR_CAUSE(INTR_CAUSE), .MIP(MIP)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
  endtask

  task automatic do_mret();
    MRET = 1'b1; tick(); MRET = 1'b0;
  endtask

  // Wait (bounded) for a request, then pop the scoreboard and compare cause.
  task automatic sb_expect_req(input string name);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (INTR_REQ === 1'b1) got = 1'b1;
      else tick();
    end
    exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: INTR_REQ never rose (timeout), expected cause %h", name, exp_c);
    end else if (INTR_CAUSE !== exp_c) begin
      n_err++;
      $display("FAIL %s: cause got %h expected %h", name, INTR_CAUSE, exp_c);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    n_cmp++;
    if (INTR_REQ !== 1'b0 || INTR_CAUSE !== 32'h0 || MIP !== 3'b000) begin
      n_err++;
      $display("FAIL reset: req=%b cause=%h mip=%b expected 0/0/000", INTR_REQ, INTR_CAUSE, MIP);
    end
  endtask

  task automatic test_timer();
    MIE_GLOBAL = 1'b1; MIE_MASK = 3'b010;
    tick();
    TIMER_INT = 1'b1;
    exp_q.push_back(C_MTI);
    tick();
    n_cmp++;
    if (INTR_REQ !== 1'b0 || MIP !== 3'b010) begin
      n_err++;
      $display("FAIL timer_edge1: req=%b mip=%b expected 0/010", INTR_REQ, MIP);
    end
    tick();
    n_cmp++;
    if (INTR_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL timer_edge2: req=%b expected 1", INTR_REQ);
    end
    sb_expect_req("timer_cause");
    do_ack();
    n_cmp++;
    if (INTR_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL timer_ack: req=%b expected 0", INTR_REQ);
    end
    // Timer still high: handler must not issue a new request.
    tick(); tick();
    n_cmp++;
    if (INTR_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL timer_handler_block: req=%b expected 0", INTR_REQ);
    end
    do_mret();
    n_cmp++;
    if (INTR_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL timer_mret_edge: req=%b expected 0", INTR_REQ);
    end
    exp_q.push_back(C_MTI);
    tick();
    n_cmp++;
    if (INTR_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL timer_reissue: req=%b expected 1", INTR_REQ);
    end
    sb_expect_req("timer_reissue_cause");
    TIMER_INT = 1'b0;
    do_ack(); do_mret(); tick();
  endtask

  task automatic test_priority();
    MIE_GLOBAL = 1'b0; MIE_MASK = 3'b111;
    TIMER_INT = 1'b1; SW_INT = 1'b1; BTN = 1'b1;
    exp_q.push_back(C_MEI);
    exp_q.push_back(C_MSI);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (MIP === 3'b111) got = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL prio_pending: mip=%b expected 111 (timeout)", MIP);
    end
    MIE_GLOBAL = 1'b1;
    tick();
    sb_expect_req("prio_first");
    BTN = 1'b0;
    do_ack();
    n_cmp++;
    if (MIP[2] !== 1'b0) begin
      n_err++;
      $display("FAIL prio_mei_clear: mip=%b expected MEI cleared", MIP);
    end
    do_mret();
    sb_expect_req("prio_second");
    SW_INT = 1'b0; TIMER_INT = 1'b0;
    do_ack(); do_mret();
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    bit saw_req;
    MIE_GLOBAL = 1'b1; MIE_MASK = 3'b100;
    saw_req = 1'b0;
    BTN = 1'b1;
    repeat (DB - 1) tick();
    BTN = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (INTR_REQ === 1'b1 || MIP[2] === 1'b1) saw_req = 1'b1;
    end
    n_cmp++;
    if (saw_req) begin
      n_err++;
      $display("FAIL glitch_reject: mip=%b req=%b expected no MEI", MIP, INTR_REQ);
    end
    exp_q.push_back(C_MEI);
    BTN = 1'b1;
    repeat (DB + 2) tick();
    BTN = 1'b0;
    sb_expect_req("glitch_stable_pulse");
    n_cmp++;
    if (MIP[2] !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_mip: mip=%b expected MEI set", MIP);
    end
    do_ack(); do_mret();
    repeat (10) tick();
  endtask

  task automatic test_hold();
    MIE_GLOBAL = 1'b1; MIE_MASK = 3'b010;
    TIMER_INT = 1'b1;
    exp_q.push_back(C_MTI);
    sb_expect_req("hold_issue");
    MIE_GLOBAL = 1'b0; MIE_MASK = 3'b000; TIMER_INT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (INTR_REQ !== 1'b1 || INTR_CAUSE !== C_MTI) begin
        n_err++;
        $display("FAIL hold_stable: req=%b cause=%h expected 1/%h", INTR_REQ, INTR_CAUSE, C_MTI);
      end
    end
    do_ack();
    n_cmp++;
    if (INTR_REQ !== 1'b0 || INTR_CAUSE !== C_MTI) begin
      n_err++;
      $display("FAIL hold_ack: req=%b cause=%h expected 0/%h", INTR_REQ, INTR_CAUSE, C_MTI);
    end
    do_mret(); tick();
  endtask

  task automatic test_global_gate();
    MIE_GLOBAL = 1'b0; MIE_MASK = 3'b100;
    BTN = 1'b1;
    repeat (DB + 2) tick();
    BTN = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (MIP[2] === 1'b1) got = 1'b1;
      else tick();
    end
    tick(); tick();
    n_cmp++;
    if (!got || MIP[2] !== 1'b1 || INTR_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL global_masked: mip=%b req=%b expected MEI pending, no req", MIP, INTR_REQ);
    end
    exp_q.push_back(C_MEI);
    MIE_GLOBAL = 1'b1;
    tick();
    n_cmp++;
    if (INTR_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL global_enable: req=%b expected 1 one edge after enable", INTR_REQ);
    end
    sb_expect_req("global_cause");
    do_ack(); do_mret();
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    MIE_GLOBAL = 1'b1; MIE_MASK = 3'b010;
    TIMER_INT = 1'b1;
    exp_q.push_back(C_MTI);
    sb_expect_req("rstmid_issue");
    TIMER_INT = 1'b0;
    RST = 1'b1; tick(); RST = 1'b0;
    n_cmp++;
    if (INTR_REQ !== 1'b0 || MIP !== 3'b000 || INTR_CAUSE !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_clear: req=%b mip=%b cause=%h expected 0/000/0", INTR_REQ, MIP, INTR_CAUSE);
    end
    // A stray ack must not push the FSM into HANDLER.
    do_ack();
    tick();
    TIMER_INT = 1'b1;
    exp_q.push_back(C_MTI);
    tick(); tick();
    n_cmp++;
    if (INTR_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_ack_ignored: req=%b expected 1 (ack after reset ignored)", INTR_REQ);
    end
    sb_expect_req("rstmid_reissue");
    TIMER_INT = 1'b0;
    do_ack(); do_mret(); tick();
  endtask

  task automatic test_btn_held();
    bit extra;
    MIE_GLOBAL = 1'b0; MIE_MASK = 3'b100;
    BTN = 1'b1;
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (MIP[2] === 1'b1) got = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL btnheld_edge: mip=%b expected MEI after reset with button held", MIP);
    end
    exp_q.push_back(C_MEI);
    MIE_GLOBAL = 1'b1;
    tick();
    sb_expect_req("btnheld_cause");
    do_ack();
    extra = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (MIP[2] !== 1'b0) extra = 1'b1;
    end
    n_cmp++;
    if (extra) begin
      n_err++;
      $display("FAIL btnheld_single: mip=%b expected only one MEI edge", MIP);
    end
    do_mret();
    BTN = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_timer();
    test_priority();
    test_glitch();
    test_hold();
    test_global_gate();
    test_reset_mid();
    test_btn_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/otter_int_ctrl.md
OTTER_INT_CTRL -- requirements
Module: otter_int_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning: consecutive cycles the synchronized button must be stable before its level is accepted.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 BTN  input  1  raw asynchronous button; external-interrupt (MEI) source.
REQ-005 TIMER_INT  input  1  level machine-timer interrupt (MTI).
REQ-006 SW_INT  input  1  level machine-software interrupt (MSI).
REQ-007 MIE_GLOBAL  input  1  mstatus.MIE from CSR file.
REQ-008 MIE_MASK  input  3  per-source enable: bit0 MSI, bit1 MTI, bit2 MEI.
REQ-009 INTR_ACK  input  1  pipeline pulse: trap taken for the current request.
REQ-010 MRET  input  1  pipeline pulse: handler returned.
REQ-011 INTR_REQ  output  1  registered interrupt request to the pipeline.
REQ-012 INTR_CAUSE  output  32  mcause value for the current request.
REQ-013 MIP  output  3  pending bits, same bit order as MIE_MASK.

Function
REQ-014 BTN shall pass a 2-flop synchronizer, then a debounce counter; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-015 A 0->1 transition of the debounced level shall set a sticky MEI pending bit in the following cycle.
REQ-016 MSI and MTI pending shall equal SW_INT and TIMER_INT registered one cycle (not sticky).
REQ-017 MIP shall present {MEI, MTI, MSI} pending bits.
REQ-018 Eligible set = MIP & MIE_MASK, gated by MIE_GLOBAL.
REQ-019 Priority: MEI > MSI > MTI; causes 0x8000000B, 0x80000003, 0x80000007.
REQ-020 FSM states IDLE, REQ, HANDLER.
REQ-021 IDLE: eligible set non-empty at edge N -> state REQ, INTR_REQ=1 and INTR_CAUSE latched from highest-priority source, visible after edge N.
REQ-022 REQ: INTR_REQ and INTR_CAUSE held stable until INTR_ACK, regardless of later mask, MIE_GLOBAL or pending changes.
REQ-023 REQ with INTR_ACK=1: state HANDLER, INTR_REQ=0 next cycle; if cause is MEI, sticky MEI bit cleared same edge.
REQ-024 HANDLER: no new request; MRET=1 -> IDLE; a new request may issue no earlier than the cycle after return to IDLE.
REQ-025 INTR_ACK outside REQ and MRET outside HANDLER shall be ignored.
REQ-026 Simultaneous INTR_ACK clearing MEI and a new debounced button edge: set wins; MEI stays pending.
REQ-027 INTR_CAUSE shall hold its last value while not in REQ.
REQ-028 MTI/MSI are not cleared by the block; software clears the source level.

Reset
REQ-029 RST=1 at an edge: state IDLE, INTR_REQ=0, INTR_CAUSE=0, MIP=0, synchronizer flops=0, debounced level=0, debounce counter=0, sticky MEI=0.
REQ-030 Reset shall override any state, including REQ mid-handshake; no request survives reset.
REQ-031 Button held high through and after reset shall produce one MEI edge once debounced (debounced level starts at 0).

Verification
REQ-032 MIE_GLOBAL=1, MIE_MASK=3'b010, TIMER_INT 0->1 -> INTR_REQ=1 with INTR_CAUSE=0x80000007 at the second edge after assertion; ACK -> INTR_REQ=0 next cycle; MRET -> IDLE.
REQ-033 TIMER_INT, SW_INT, BTN all asserted, all enabled -> first cause 0x8000000B; after ACK/MRET with BTN released, next cause 0x80000003.
REQ-034 BTN glitch of DEBOUNCE_CYCLES-1 cycles -> MIP[2] stays 0, no request; stable pulse of DEBOUNCE_CYCLES+2 -> MIP[2]=1.
REQ-035 In REQ, MIE_GLOBAL dropped to 0 and MIE_MASK cleared -> INTR_REQ and INTR_CAUSE unchanged until ACK.
REQ-036 MIE_GLOBAL=0, MEI pending -> MIP[2]=1, INTR_REQ stays 0; set MIE_GLOBAL=1 -> INTR_REQ=1 next edge, cause 0x8000000B.
REQ-037 RST asserted while INTR_REQ=1 -> INTR_REQ=0, MIP=3'b000, INTR_CAUSE=0 after the reset edge; ACK after reset ignored.
